// File: rtl/keychain_cmd_ctrl.sv
// Command sequencer between the UART byte streams and the keychain cipher core.
// Optional inter-byte frame timeout is enabled by defining KEYCHAIN_TIMEOUT_EN.
module keychain_cmd_ctrl #(
  parameter int KEY_BYTES = 2,
  parameter int MSG_BYTES = 1
`ifdef KEYCHAIN_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1_000_000
`endif
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   rx_valid_in,
  input  logic [7:0]             rx_data_in,
  input  logic                   tx_ready_in,
  output logic                   tx_valid_out,
  output logic [7:0]             tx_data_out,
  output logic [8*KEY_BYTES-1:0] key_out,
  output logic                   key_valid_out,
  output logic [8*MSG_BYTES-1:0] msg_out,
  output logic                   start_out,
  input  logic                   core_done_in,
  input  logic [8*MSG_BYTES-1:0] core_result_in,
  output logic                   busy_out,
  output logic                   err_out
);

  localparam int KW    = 8 * KEY_BYTES;
  localparam int MW    = 8 * MSG_BYTES;
  localparam int MAXB  = (KEY_BYTES > MSG_BYTES) ? KEY_BYTES : MSG_BYTES;
  localparam int CNT_W = $clog2(MAXB + 1);
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BYTES - 1);
  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_BYTES - 1);
  localparam logic [7:0] OP_KEY   = 8'h4B;
  localparam logic [7:0] OP_ENC   = 8'h45;
  localparam logic [7:0] BYTE_ACK = 8'h06;
  localparam logic [7:0] BYTE_NAK = 8'h15;
  localparam logic [7:0] BYTE_ERR = 8'h21;

  typedef enum logic [2:0] {
    S_IDLE, S_KEY_RX, S_MSG_RX, S_START, S_WAIT, S_TX, S_ACK
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [KW-1:0]    shadow;
  logic [KW-1:0]    key_shift;
  logic [MW-1:0]    msg_shift;
  logic [MW-1:0]    res;
  logic [7:0]       ack_byte;
  logic             rx_state, key_last, msg_last, rx_drop, bad_op, no_key_end;
  logic             tmo_hit;

  assign key_shift  = (shadow << 8) | KW'(rx_data_in);
  assign msg_shift  = (msg_out << 8) | MW'(rx_data_in);
  assign rx_state   = (state == S_KEY_RX) || (state == S_MSG_RX);
  assign key_last   = rx_valid_in && (cnt == KEY_LAST);
  assign msg_last   = rx_valid_in && (cnt == MSG_LAST);
  assign bad_op     = (state == S_IDLE) && rx_valid_in &&
                      (rx_data_in != OP_KEY) && (rx_data_in != OP_ENC);
  assign rx_drop    = rx_valid_in && (state inside {S_START, S_WAIT, S_TX, S_ACK});
  assign no_key_end = (state == S_MSG_RX) && msg_last && !key_valid_out;

`ifdef KEYCHAIN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Idle-cycle counter, only live while a frame is being collected
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                     tmo_cnt <= '0;
    else if (rx_state && !rx_valid_in) tmo_cnt <= tmo_cnt + TW'(1);
    else                               tmo_cnt <= '0;
  end

  assign tmo_hit = rx_state && !rx_valid_in && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (rx_valid_in) begin
          if (rx_data_in == OP_KEY)      state_nxt = S_KEY_RX;
          else if (rx_data_in == OP_ENC) state_nxt = S_MSG_RX;
          else                           state_nxt = S_ACK;
        end
      S_KEY_RX:
        if (key_last)     state_nxt = S_ACK;
        else if (tmo_hit) state_nxt = S_IDLE;
      S_MSG_RX:
        if (msg_last)     state_nxt = key_valid_out ? S_START : S_ACK;
        else if (tmo_hit) state_nxt = S_IDLE;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (core_done_in) state_nxt = S_TX;
      S_TX:    if (tx_ready_in && (cnt == MSG_LAST)) state_nxt = S_IDLE;
      S_ACK:   if (tx_ready_in) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_out     = (state != S_IDLE);
    start_out    = (state == S_START);
    tx_valid_out = (state == S_TX) || (state == S_ACK);
    tx_data_out  = 8'h00;
    if (state == S_TX)       tx_data_out = res[MW-1 -: 8];
    else if (state == S_ACK) tx_data_out = ack_byte;
  end

  // Frame datapath: key commits atomically on the last key byte; msg_out only moves in MSG_RX
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt           <= '0;
      shadow        <= '0;
      key_out       <= '0;
      key_valid_out <= 1'b0;
      msg_out       <= '0;
      res           <= '0;
      ack_byte      <= 8'h00;
      err_out       <= 1'b0;
    end else begin
      err_out <= bad_op || rx_drop || no_key_end || tmo_hit;
      case (state)
        S_IDLE:
          if (rx_valid_in) begin
            cnt <= '0;
            if (bad_op) ack_byte <= BYTE_NAK;
          end
        S_KEY_RX:
          if (rx_valid_in) begin
            cnt    <= cnt + CNT_W'(1);
            shadow <= key_shift;
            if (key_last) begin
              key_out       <= key_shift;
              key_valid_out <= 1'b1;
              ack_byte      <= BYTE_ACK;
            end
          end else if (tmo_hit) begin
            shadow <= '0;
          end
        S_MSG_RX:
          if (rx_valid_in) begin
            cnt <= cnt + CNT_W'(1);
            if (key_valid_out) msg_out <= msg_shift;
            if (no_key_end) ack_byte <= BYTE_ERR;
          end
        S_WAIT:
          if (core_done_in) begin
            res <= core_result_in;
            cnt <= '0;
          end
        S_TX:
          if (tx_ready_in) begin
            res <= res << 8;
            cnt <= cnt + CNT_W'(1);
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keychain_cmd_ctrl.sv
// Directed bench for keychain_cmd_ctrl (default build, KEY_BYTES=2, MSG_BYTES=1).
module tb_keychain_cmd_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rx_valid_in;
  logic [7:0]  rx_data_in;
  logic        tx_ready_in;
  logic        tx_valid_out;
  logic [7:0]  tx_data_out;
  logic [15:0] key_out;
  logic        key_valid_out;
  logic [7:0]  msg_out;
  logic        start_out;
  logic        core_done_in;
  logic [7:0]  core_result_in;
  logic        busy_out;
  logic        err_out;

  int n_vec = 0;
  int n_err = 0;

  keychain_cmd_ctrl #(.KEY_BYTES(2), .MSG_BYTES(1)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .rx_valid_in(rx_valid_in), .rx_data_in(rx_data_in),
    .tx_ready_in(tx_ready_in), .tx_valid_out(tx_valid_out), .tx_data_out(tx_data_out),
    .key_out(key_out), .key_valid_out(key_valid_out), .msg_out(msg_out),
    .start_out(start_out), .core_done_in(core_done_in), .core_result_in(core_result_in),
    .busy_out(busy_out), .err_out(err_out)
  );

  always #50 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid_in = 1'b1;
    rx_data_in  = b;
    tick();
    rx_valid_in = 1'b0;
    rx_data_in  = 8'h00;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    #20;
    chk("rst_tx_valid", 32'(tx_valid_out), 32'd0);
    chk("rst_key_valid", 32'(key_valid_out), 32'd0);
    chk("rst_key", 32'(key_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_start", 32'(start_out), 32'd0);
    chk("rst_err", 32'(err_out), 32'd0);
    tick();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    tick();
  endtask

  initial begin
    rx_valid_in    = 1'b0;
    rx_data_in     = 8'h00;
    tx_ready_in    = 1'b0;
    core_done_in   = 1'b0;
    core_result_in = 8'h00;
    do_reset();

    // key load: 4B,12,34 then ACK
    send(8'h4B);
    chk("key_busy", 32'(busy_out), 32'd1);
    send(8'h12);
    chk("key_partial_valid", 32'(key_valid_out), 32'd0);
    chk("key_partial_out", 32'(key_out), 32'd0);
    send(8'h34);
    chk("key_out", 32'(key_out), 32'h1234);
    chk("key_valid", 32'(key_valid_out), 32'd1);
    chk("ack_valid", 32'(tx_valid_out), 32'd1);
    chk("ack_data", 32'(tx_data_out), 32'h06);
    tx_ready_in = 1'b1;
    tick();
    tx_ready_in = 1'b0;
    chk("ack_done_valid", 32'(tx_valid_out), 32'd0);
    chk("ack_done_busy", 32'(busy_out), 32'd0);

    // encrypt: 45,A5 -> start, WAIT, drop during WAIT, result 5A
    send(8'h45);
    send(8'hA5);
    chk("enc_start", 32'(start_out), 32'd1);
    chk("enc_msg", 32'(msg_out), 32'hA5);
    tick();
    chk("enc_start_once", 32'(start_out), 32'd0);
    chk("enc_wait_busy", 32'(busy_out), 32'd1);
    send(8'h4B);
    chk("wait_drop_err", 32'(err_out), 32'd1);
    chk("wait_drop_busy", 32'(busy_out), 32'd1);
    tick();
    chk("wait_err_pulse", 32'(err_out), 32'd0);
    chk("wait_no_tx", 32'(tx_valid_out), 32'd0);
    chk("wait_msg_held", 32'(msg_out), 32'hA5);
    core_done_in   = 1'b1;
    core_result_in = 8'h5A;
    tick();
    core_done_in   = 1'b0;
    core_result_in = 8'h00;
    chk("res_valid", 32'(tx_valid_out), 32'd1);
    chk("res_data", 32'(tx_data_out), 32'h5A);
    tick();
    chk("res_stall_data", 32'(tx_data_out), 32'h5A);
    tx_ready_in = 1'b1;
    tick();
    tx_ready_in = 1'b0;
    chk("res_done_valid", 32'(tx_valid_out), 32'd0);
    chk("res_done_busy", 32'(busy_out), 32'd0);

    // core_done outside WAIT is ignored
    core_done_in   = 1'b1;
    core_result_in = 8'hEE;
    tick();
    core_done_in   = 1'b0;
    chk("stray_done_busy", 32'(busy_out), 32'd0);
    chk("stray_done_tx", 32'(tx_valid_out), 32'd0);

    // encrypt without key after reset -> error byte 0x21
    do_reset();
    send(8'h45);
    chk("nokey_no_err_yet", 32'(err_out), 32'd0);
    send(8'hA5);
    chk("nokey_start", 32'(start_out), 32'd0);
    chk("nokey_err", 32'(err_out), 32'd1);
    chk("nokey_tx_valid", 32'(tx_valid_out), 32'd1);
    chk("nokey_tx_data", 32'(tx_data_out), 32'h21);
    chk("nokey_msg", 32'(msg_out), 32'h00);
    tick();
    chk("nokey_err_pulse", 32'(err_out), 32'd0);
    tx_ready_in = 1'b1;
    tick();
    tx_ready_in = 1'b0;
    chk("nokey_done_busy", 32'(busy_out), 32'd0);

    // bad opcode -> NAK held under backpressure
    send(8'h7F);
    chk("nak_err", 32'(err_out), 32'd1);
    chk("nak_valid", 32'(tx_valid_out), 32'd1);
    chk("nak_data", 32'(tx_data_out), 32'h15);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("nak_hold_%0d", i), 32'(tx_data_out), 32'h15);
    end
    chk("nak_hold_valid", 32'(tx_valid_out), 32'd1);
    tx_ready_in = 1'b1;
    tick();
    tx_ready_in = 1'b0;
    chk("nak_done_valid", 32'(tx_valid_out), 32'd0);
    chk("nak_done_busy", 32'(busy_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
